tla_multi_cap: RTL and testbench

Multi-channel, parametrised capture sequencer in the Gc_clk125 domain. It takes the already-synchronised, packed ADC sample stream and capture configuration from the clock-crossing layer. On a trigger it waits a programmable number of samples, then forwards a power-of-two window of channel-masked samples. It reports completion through a ready flag and optionally tracks overflow per channel. It generalises the single-channel trigger/ready path to N channels, with single or continuous re-arm, abort, and pre-window delay.

---
 rtl/tla_cap_pkg.sv | 19 +
 rtl/tla_cap_cnt.sv | 28 ++
 rtl/tla_multi_cap.sv | 184 ++++++++++++++++++
 tb/tb_tla_multi_cap.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tla_cap_pkg.sv
// Shared types and helpers for the tla_multi_cap capture sequencer.
package tla_cap_pkg;

  localparam int unsigned WinMinLog2Def = 4;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StDelay,
    StCapt,
    StDone
  } cap_state_e;

  // Number of samples in a capture window for a given window-select code.
  function automatic int unsigned win_len(input int unsigned wdis, input int unsigned min_log2);
    return 32'd1 << (wdis + min_log2);
  endfunction

endpackage

// File: rtl/tla_cap_cnt.sv
// Loadable down-counter with enable and zero flag; load has priority over enable.
module tla_cap_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  // Saturates at zero so the maximum window never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tla_multi_cap.sv
// Multi-channel trigger/delay/window capture sequencer in the Gc_clk125 domain.
// Optional sticky per-channel overflow tracking: define TLA_CAP_OF_STICKY_EN.
module tla_multi_cap
  import tla_cap_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned ADC_W        = 14,
  parameter int unsigned WDIS_W       = 3,
  parameter int unsigned PLUS_W       = 32,
  parameter int unsigned WIN_MIN_LOG2 = WinMinLog2Def
) (
  input  logic                    Gc_clk125,
  input  logic                    Gc_rst_n,
  input  logic                    Gc_adc_vld,
  input  logic [CH_NUM*ADC_W-1:0] Gc_adc_data,
  input  logic [CH_NUM-1:0]       Gc_adc_of,
  input  logic [CH_NUM-1:0]       Gc_ch_mask,
  input  logic                    Gc_cap_mode,
  input  logic [WDIS_W-1:0]       Gc_cap_wdis,
  input  logic [PLUS_W-1:0]       Gc_cap_plus,
  input  logic                    Gc_cap_start,
  input  logic                    Gc_cap_trig,
  input  logic                    Gc_cap_abort,
  output logic                    Gc_cap_vld,
  output logic [CH_NUM*ADC_W-1:0] Gc_cap_data,
  output logic                    Gc_cap_last,
  output logic                    Gc_capr_rdy,
  output logic                    Gc_busy,
  output logic [CH_NUM-1:0]       Gc_cap_of
);

  localparam int unsigned WinCntW = WIN_MIN_LOG2 + (1 << WDIS_W) - 1;
  localparam int unsigned DataW   = CH_NUM * ADC_W;

  cap_state_e state_q, state_d;

  logic              sh_mode_q;
  logic [WDIS_W-1:0] sh_wdis_q;
  logic [PLUS_W-1:0] sh_plus_q;
  logic [CH_NUM-1:0] sh_mask_q;

  logic               dly_load, dly_en, dly_zero;
  logic               win_load, win_en, win_zero;
  logic [PLUS_W-1:0]  dly_load_val;
  logic [WinCntW-1:0] win_load_val;
  logic               latch_cfg, clr_flags, emit, emit_last;
  logic [DataW-1:0]   lane_mask;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      lane_mask[i*ADC_W +: ADC_W] = {ADC_W{sh_mask_q[i]}};
    end
  end

  // The sample that empties the delay counter is itself skipped, hence plus-1.
  assign dly_load_val = sh_plus_q - PLUS_W'(1);
  assign win_load_val = WinCntW'(win_len(32'(sh_wdis_q), WIN_MIN_LOG2) - 32'd1);

  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    clr_flags = 1'b0;
    dly_load  = 1'b0;
    win_load  = 1'b0;
    dly_en    = 1'b0;
    win_en    = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    if (Gc_cap_abort) begin
      state_d   = StIdle;
      clr_flags = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (Gc_cap_start) begin
            state_d   = StArm;
            latch_cfg = 1'b1;
            clr_flags = 1'b1;
          end
        end
        StArm: begin
          if (Gc_cap_trig) begin
            dly_load  = 1'b1;
            win_load  = 1'b1;
            clr_flags = 1'b1;
            state_d   = (sh_plus_q != '0) ? StDelay : StCapt;
          end
        end
        StDelay: begin
          if (Gc_adc_vld) begin
            if (dly_zero) state_d = StCapt;
            else          dly_en  = 1'b1;
          end
        end
        StCapt: begin
          if (Gc_adc_vld) begin
            emit = 1'b1;
            if (win_zero) begin
              emit_last = 1'b1;
              state_d   = sh_mode_q ? StArm : StDone;
            end else begin
              win_en = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      state_q     <= StIdle;
      sh_mode_q   <= 1'b0;
      sh_wdis_q   <= '0;
      sh_plus_q   <= '0;
      sh_mask_q   <= '0;
      Gc_cap_vld  <= 1'b0;
      Gc_cap_data <= '0;
      Gc_cap_last <= 1'b0;
      Gc_capr_rdy <= 1'b0;
      Gc_busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_cfg) begin
        sh_mode_q <= Gc_cap_mode;
        sh_wdis_q <= Gc_cap_wdis;
        sh_plus_q <= Gc_cap_plus;
        sh_mask_q <= Gc_ch_mask;
      end
      Gc_cap_vld  <= emit;
      Gc_cap_last <= emit_last;
      if (emit) Gc_cap_data <= Gc_adc_data & lane_mask;
      Gc_busy <= (state_d == StArm) || (state_d == StDelay) || (state_d == StCapt);
      // A clear in the same cycle wins, since it opens a new window.
      if (clr_flags)        Gc_capr_rdy <= 1'b0;
      else if (Gc_cap_last) Gc_capr_rdy <= 1'b1;
    end
  end

`ifdef TLA_CAP_OF_STICKY_EN
  logic [CH_NUM-1:0] cap_of_q;

  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      cap_of_q <= '0;
    end else if (clr_flags) begin
      cap_of_q <= '0;
    end else if (emit) begin
      cap_of_q <= cap_of_q | (Gc_adc_of & sh_mask_q);
    end
  end

  assign Gc_cap_of = cap_of_q;
`else
  logic unused_adc_of;
  assign unused_adc_of = ^Gc_adc_of;
  assign Gc_cap_of     = '0;
`endif

  tla_cap_cnt #(
    .Width(PLUS_W)
  ) u_dly_cnt (
    .clk_i     (Gc_clk125),
    .rst_ni    (Gc_rst_n),
    .load_i    (dly_load),
    .load_val_i(dly_load_val),
    .en_i      (dly_en),
    .zero_o    (dly_zero)
  );

  tla_cap_cnt #(
    .Width(WinCntW)
  ) u_win_cnt (
    .clk_i     (Gc_clk125),
    .rst_ni    (Gc_rst_n),
    .load_i    (win_load),
    .load_val_i(win_load_val),
    .en_i      (win_en),
    .zero_o    (win_zero)
  );

endmodule

// File: tb/tb_tla_multi_cap.sv
// Scoreboard bench for tla_multi_cap: stimulus pushes expected samples, a monitor pops and compares.
module tb_tla_multi_cap;

  localparam int DW = 56;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          adc_vld = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [3:0]    adc_of = '0;
  logic [3:0]    ch_mask = 4'hF;
  logic          cap_mode = 1'b0;
  logic [2:0]    cap_wdis = '0;
  logic [31:0]   cap_plus = '0;
  logic          cap_start = 1'b0;
  logic          cap_trig = 1'b0;
  logic          cap_abort = 1'b0;
  logic          cap_vld, cap_last, capr_rdy, busy;
  logic [DW-1:0] cap_data;
  logic [3:0]    cap_of;

`ifdef TLA_CAP_OF_STICKY_EN
  localparam logic [3:0] OfHit = 4'b0100;
`else
  localparam logic [3:0] OfHit = 4'b0000;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vld_count = 0;
  bit   rdy_pending = 1'b0;

  tla_multi_cap dut (
    .Gc_clk125   (clk),
    .Gc_rst_n    (rst_n),
    .Gc_adc_vld  (adc_vld),
    .Gc_adc_data (adc_data),
    .Gc_adc_of   (adc_of),
    .Gc_ch_mask  (ch_mask),
    .Gc_cap_mode (cap_mode),
    .Gc_cap_wdis (cap_wdis),
    .Gc_cap_plus (cap_plus),
    .Gc_cap_start(cap_start),
    .Gc_cap_trig (cap_trig),
    .Gc_cap_abort(cap_abort),
    .Gc_cap_vld  (cap_vld),
    .Gc_cap_data (cap_data),
    .Gc_cap_last (cap_last),
    .Gc_capr_rdy (capr_rdy),
    .Gc_busy     (busy),
    .Gc_cap_of   (cap_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int base, input int idx);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[i*14 +: 14] = 14'((base << 8) + (idx << 2) + i);
    return d;
  endfunction

  function automatic logic [DW-1:0] mask_data(input logic [DW-1:0] d, input logic [3:0] m);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < 4; i++) if (!m[i]) r[i*14 +: 14] = '0;
    return r;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic vld, input logic [DW-1:0] d, input logic [3:0] of,
                       input logic trg, input logic abt);
    adc_vld   = vld;
    adc_data  = d;
    adc_of    = of;
    cap_trig  = trg;
    cap_abort = abt;
    @(negedge clk);
    adc_vld   = 1'b0;
    adc_of    = '0;
    cap_trig  = 1'b0;
    cap_abort = 1'b0;
  endtask

  task automatic start_cap(input logic mode, input logic [2:0] wdis, input logic [31:0] plus,
                           input logic [3:0] mask);
    cap_mode  = mode;
    cap_wdis  = wdis;
    cap_plus  = plus;
    ch_mask   = mask;
    cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
  endtask

  // Sample k (k=1 is the first valid after the trigger) is captured when plus < k <= plus+len.
  task automatic send(input int first, input int last, input int gap, input int plus,
                      input int len, input logic [3:0] mask, input int base);
    for (int k = first; k <= last; k++) begin
      repeat (gap) @(negedge clk);
      if (k > plus && k <= plus + len) push(mask_data(mk_data(base, k), mask), k == plus + len);
      drive(1'b1, mk_data(base, k), 4'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compares every presented sample against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rdy_pending) begin
        chk("capr_rdy_after_last", capr_rdy, 1);
        rdy_pending = 1'b0;
      end
      if (cap_vld) begin
        vld_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_cap_vld", cap_vld, 0);
        end else begin
          e = exp_q.pop_front();
          chk("cap_data", cap_data, e.data);
          chk("cap_last", cap_last, e.last);
          if (e.last) begin
            chk("capr_rdy_at_last", capr_rdy, 0);
            rdy_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cap_vld", cap_vld, 0);
    chk("rst_cap_last", cap_last, 0);
    chk("rst_capr_rdy", capr_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cap_data", cap_data, 0);
    chk("rst_cap_of", cap_of, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single capture, 16 samples, trigger-cycle sample excluded.
    vld_count = 0;
    start_cap(1'b0, 3'd0, 32'd0, 4'hF);
    chk("busy_after_start", busy, 1);
    drive(1'b1, mk_data(1, 0), 4'b0, 1'b1, 1'b0);
    send(1, 20, 0, 0, 16, 4'hF, 1);
    repeat (2) @(negedge clk);
    chk("single_count", vld_count, 16);
    chk("single_done_busy", busy, 0);
    chk("single_done_rdy", capr_rdy, 1);
    drive(1'b1, mk_data(2, 0), 4'b0, 1'b1, 1'b0);
    send(1, 4, 0, 0, 0, 4'hF, 2);
    chk("done_trig_ignored", vld_count, 16);

    // Delay of 5 with vld every 3rd cycle.
    vld_count = 0;
    start_cap(1'b0, 3'd0, 32'd5, 4'hF);
    chk("rdy_cleared_by_start", capr_rdy, 0);
    drive(1'b1, mk_data(3, 0), 4'b0, 1'b1, 1'b0);
    send(1, 25, 2, 5, 16, 4'hF, 3);
    repeat (2) @(negedge clk);
    chk("delay_count", vld_count, 16);

    // Channel masking.
    vld_count = 0;
    start_cap(1'b0, 3'd0, 32'd0, 4'b0101);
    drive(1'b1, mk_data(4, 0), 4'b0, 1'b1, 1'b0);
    send(1, 16, 0, 0, 16, 4'b0101, 4);
    repeat (2) @(negedge clk);
    chk("mask_count", vld_count, 16);

    // Continuous mode: three 32-sample windows.
    vld_count = 0;
    start_cap(1'b1, 3'd1, 32'd0, 4'hF);
    for (int w = 0; w < 3; w++) begin
      if (w > 0) chk("cont_rdy_before_trig", capr_rdy, 1);
      drive(1'b1, mk_data(10 + w, 0), 4'b0, 1'b1, 1'b0);
      if (w > 0) chk("cont_rdy_cleared", capr_rdy, 0);
      if (w == 1) begin
        send(1, 10, 0, 0, 32, 4'hF, 10 + w);
        push(mk_data(10 + w, 11), 1'b0);
        drive(1'b1, mk_data(10 + w, 11), 4'b0, 1'b1, 1'b0);
        send(12, 32, 0, 0, 32, 4'hF, 10 + w);
      end else if (w == 2) begin
        send(1, 31, 0, 0, 32, 4'hF, 10 + w);
        push(mk_data(10 + w, 32), 1'b1);
        drive(1'b1, mk_data(10 + w, 32), 4'b0, 1'b1, 1'b0);
        send(1, 5, 0, 0, 0, 4'hF, 20);
      end else begin
        send(1, 32, 0, 0, 32, 4'hF, 10 + w);
      end
      @(negedge clk);
    end
    chk("cont_count", vld_count, 96);
    chk("cont_busy_armed", busy, 1);
    chk("cont_rdy_held", capr_rdy, 1);
    drive(1'b0, '0, 4'b0, 1'b0, 1'b1);
    chk("cont_abort_busy", busy, 0);
    chk("cont_abort_rdy", capr_rdy, 0);

    // Abort at sample 10 of 16.
    vld_count = 0;
    start_cap(1'b0, 3'd0, 32'd0, 4'hF);
    drive(1'b1, mk_data(5, 0), 4'b0, 1'b1, 1'b0);
    send(1, 9, 0, 0, 16, 4'hF, 5);
    drive(1'b1, mk_data(5, 10), 4'b0, 1'b0, 1'b1);
    chk("abort_busy_next", busy, 0);
    send(11, 20, 0, 0, 0, 4'hF, 5);
    chk("abort_count", vld_count, 9);
    chk("abort_rdy", capr_rdy, 0);

    // Abort beats trigger in ARM.
    vld_count = 0;
    start_cap(1'b0, 3'd0, 32'd0, 4'hF);
    drive(1'b1, mk_data(6, 0), 4'b0, 1'b1, 1'b1);
    chk("abort_trig_busy", busy, 0);
    send(1, 20, 0, 0, 0, 4'hF, 6);
    chk("abort_trig_count", vld_count, 0);

    // Asynchronous reset mid-window.
    start_cap(1'b0, 3'd0, 32'd0, 4'hF);
    drive(1'b1, mk_data(7, 0), 4'b0, 1'b1, 1'b0);
    send(1, 5, 0, 0, 16, 4'hF, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cap_vld", cap_vld, 0);
    chk("midrst_cap_data", cap_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_capr_rdy", capr_rdy, 0);
    chk("midrst_cap_last", cap_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Overflow: lane 2 hit while capturing; delay-phase and masked-lane hits ignored.
    vld_count = 0;
    start_cap(1'b0, 3'd0, 32'd2, 4'b0111);
    drive(1'b1, mk_data(8, 0), 4'b0100, 1'b1, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      logic [3:0] of;
      of = (k == 1 || k == 4) ? 4'b0100 : ((k == 5) ? 4'b1000 : 4'b0000);
      if (k > 2) push(mask_data(mk_data(8, k), 4'b0111), k == 18);
      drive(1'b1, mk_data(8, k), of, 1'b0, 1'b0);
      if (k == 3) chk("of_delay_ignored", cap_of, 0);
      if (k == 4) chk("of_set", cap_of, OfHit);
      if (k == 5) chk("of_masked_ignored", cap_of, OfHit);
    end
    repeat (3) @(negedge clk);
    chk("of_count", vld_count, 16);
    chk("of_held", cap_of, OfHit);
    start_cap(1'b0, 3'd0, 32'd0, 4'hF);
    chk("of_cleared_by_start", cap_of, 0);
    drive(1'b0, '0, 4'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
